// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// ALU operation codes, datapath select encodings and the control-word decode.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_RTYPE  = 5'd2,
    S_RWRITE = 5'd3,
    S_IMM    = 5'd4,
    S_IMM2   = 5'd5,
    S_ADDR   = 5'd6,
    S_LW1    = 5'd7,
    S_LW2    = 5'd8,
    S_SW     = 5'd9,
    S_BEQ    = 5'd10,
    S_BNE    = 5'd11,
    S_JMP    = 5'd12,
    S_JAL1   = 5'd13,
    S_JAL2   = 5'd14,
    S_JR     = 5'd15,
    S_IN     = 5'd16,
    S_OUT    = 5'd17,
    S_HALT   = 5'd18
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_ADDI  = 6'd1;
  localparam logic [5:0] OPC_LW    = 6'd2;
  localparam logic [5:0] OPC_SW    = 6'd3;
  localparam logic [5:0] OPC_ORI   = 6'd4;
  localparam logic [5:0] OPC_ANDI  = 6'd5;
  localparam logic [5:0] OPC_BEQ   = 6'd7;
  localparam logic [5:0] OPC_BNE   = 6'd8;
  localparam logic [5:0] OPC_JMP   = 6'd9;
  localparam logic [5:0] OPC_JAL   = 6'd10;
  localparam logic [5:0] OPC_JR    = 6'd11;
  localparam logic [5:0] OPC_IO    = 6'd12;
  localparam logic [5:0] OPC_HALT  = 6'd15;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] WB_MDR   = 2'd0;
  localparam logic [1:0] WB_ALU   = 2'd1;
  localparam logic [1:0] WB_IN    = 2'd2;
  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;
  localparam logic [1:0] PC_ALU   = 2'd0;
  localparam logic [1:0] PC_JUMP  = 2'd1;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dest;
    logic [1:0] pc_src;
    logic       mem_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch_cond;
    logic       output_write;
    logic       halted;
  } ctrl_t;

  // Handshake strobes (FETCH ir/pc write, IN reg write) are set here
  // unconditionally and qualified by the live handshake input at the top.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] rtype_alu,
                                       input logic [2:0] imm_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.src_b = SRCB_ONE; c.alu_op = ALU_ADD;
                      c.ir_write = 1'b1; c.pc_write = 1'b1; end
      S_DECODE: begin c.src_a = 1'b1; c.alu_op = ALU_ADD; end
      S_RTYPE:  begin c.src_a = 1'b1; c.alu_op = rtype_alu; end
      S_RWRITE: begin c.reg_write = 1'b1; c.mem_to_reg = WB_ALU; c.reg_dest = DST_RD; end
      S_IMM:    begin c.src_a = 1'b1; c.src_b = SRCB_IMM; c.alu_op = imm_alu; end
      S_IMM2:   begin c.reg_write = 1'b1; c.mem_to_reg = WB_ALU; c.reg_dest = DST_RT; end
      S_ADDR:   begin c.src_a = 1'b1; c.src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      S_SW:     begin c.mem_write = 1'b1; c.mem_src = 1'b1; end
      S_LW1:    begin c.mem_read = 1'b1; c.mem_src = 1'b1; end
      S_LW2:    begin c.reg_write = 1'b1; c.mem_to_reg = WB_MDR; c.reg_dest = DST_RT; end
      S_JAL1:   begin c.src_b = SRCB_ONE; c.alu_op = ALU_ADD; end
      S_JAL2:   begin c.reg_write = 1'b1; c.mem_to_reg = WB_ALU; c.reg_dest = DST_RA;
                      c.pc_write = 1'b1; c.pc_src = PC_JUMP; end
      S_JR:     begin c.src_a = 1'b1; c.alu_op = ALU_ADD; c.pc_write = 1'b1; c.pc_src = PC_ALU; end
      S_JMP:    begin c.pc_write = 1'b1; c.pc_src = PC_JUMP; end
      S_BEQ:    begin c.src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write = 1'b1; c.branch_cond = 1'b1; end
      S_BNE:    begin c.src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write = 1'b1; c.branch_cond = 1'b0; end
      S_IN:     begin c.mem_to_reg = WB_IN; c.reg_dest = DST_RD; c.reg_write = 1'b1; end
      S_OUT:    c.output_write = 1'b1;
      S_HALT:   c.halted = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: maps the instruction fields to the state that
// follows DECODE, plus the ALU operations picked by the opcode/funct.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int FN_W = 3
) (
  input  logic [OP_W-1:0] Opcode,
  input  logic [FN_W-1:0] Funct,
  output state_t          target,
  output logic            is_load,
  output logic [2:0]      imm_alu,
  output logic [2:0]      rtype_alu
);

  logic [5:0] opc;
  assign opc = 6'(Opcode);
  assign rtype_alu = Funct[2:0];

  always_comb begin
    target  = S_HALT;
    is_load = 1'b0;
    imm_alu = ALU_ADD;
    case (opc)
      OPC_RTYPE: target = S_RTYPE;
      OPC_ADDI:  target = S_IMM;
      OPC_ORI:   begin target = S_IMM; imm_alu = ALU_OR; end
      OPC_ANDI:  begin target = S_IMM; imm_alu = ALU_AND; end
      OPC_LW:    begin target = S_ADDR; is_load = 1'b1; end
      OPC_SW:    target = S_ADDR;
      OPC_BEQ:   target = S_BEQ;
      OPC_BNE:   target = S_BNE;
      OPC_JMP:   target = S_JMP;
      OPC_JAL:   target = S_JAL1;
      OPC_JR:    target = S_JR;
      OPC_IO:    target = Funct[0] ? S_IN : S_OUT;
      OPC_HALT:  target = S_HALT;
      default:   target = S_HALT;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM. The control word is registered alongside the
// state, so outputs are a pure function of the current state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int FN_W = 3
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic [OP_W-1:0] Opcode,
  input  logic [FN_W-1:0] Funct,
  input  logic            MemReady,
  input  logic            InValid,
  input  logic            OutReady,
  output logic [2:0]      ALUOp,
  output logic            SrcA,
  output logic [1:0]      SrcB,
  output logic [1:0]      MemtoReg,
  output logic [1:0]      RegDest,
  output logic [1:0]      PCSrc,
  output logic            MemSrc,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            BranchCond,
  output logic            OutputWrite,
  output logic            Halted,
  output logic [4:0]      State
);

  state_t     state, state_next;
  logic       running;
  ctrl_t      ctrl;
  state_t     dec_target;
  logic       dec_is_load;
  logic [2:0] dec_imm_alu, dec_rtype_alu;

  ctrl_decode #(.OP_W(OP_W), .FN_W(FN_W)) u_decode (
    .Opcode    (Opcode),
    .Funct     (Funct),
    .target    (dec_target),
    .is_load   (dec_is_load),
    .imm_alu   (dec_imm_alu),
    .rtype_alu (dec_rtype_alu)
  );

  // The first edge after reset only activates FETCH; it does not advance it.
  always_comb begin
    state_next = state;
    if (!running) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (MemReady) state_next = S_DECODE;
        S_DECODE: state_next = dec_target;
        S_RTYPE:  state_next = S_RWRITE;
        S_IMM:    state_next = S_IMM2;
        S_ADDR:   state_next = dec_is_load ? S_LW1 : S_SW;
        S_LW1:    if (MemReady) state_next = S_LW2;
        S_SW:     if (MemReady) state_next = S_FETCH;
        S_JAL1:   state_next = S_JAL2;
        S_IN:     if (InValid) state_next = S_FETCH;
        S_OUT:    if (OutReady) state_next = S_FETCH;
        S_HALT:   state_next = S_HALT;
        default:  state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_FETCH;
      running <= 1'b0;
      ctrl    <= '0;
    end else begin
      state   <= state_next;
      running <= 1'b1;
      ctrl    <= state_ctrl(state_next, dec_rtype_alu, dec_imm_alu);
    end
  end

  // ir_write is only set in FETCH and WB_IN only in IN, so they identify the handshake states.
  assign IRWrite     = ctrl.ir_write & MemReady;
  assign PCWrite     = ctrl.pc_write & (ctrl.ir_write ? MemReady : 1'b1);
  assign RegWrite    = ctrl.reg_write & ((ctrl.mem_to_reg == WB_IN) ? InValid : 1'b1);
  assign ALUOp       = ctrl.alu_op;
  assign SrcA        = ctrl.src_a;
  assign SrcB        = ctrl.src_b;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDest     = ctrl.reg_dest;
  assign PCSrc       = ctrl.pc_src;
  assign MemSrc      = ctrl.mem_src;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign BranchCond  = ctrl.branch_cond;
  assign OutputWrite = ctrl.output_write;
  assign Halted      = ctrl.halted;
  assign State       = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected output words are queued as each
// step is driven and popped for comparison when the DUT outputs are sampled.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic [3:0] Opcode;
  logic [2:0] Funct;
  logic       MemReady, InValid, OutReady;
  logic [2:0] ALUOp;
  logic       SrcA, MemSrc, RegWrite, MemRead, MemWrite, IRWrite, PCWrite;
  logic       BranchCond, OutputWrite, Halted;
  logic [1:0] SrcB, MemtoReg, RegDest, PCSrc;
  logic [4:0] State;

  int checks = 0;
  int errors = 0;
  logic [25:0] sb_q[$];

  localparam logic [7:0] RW = 8'h80, MR = 8'h40, MW = 8'h20, IR = 8'h10;
  localparam logic [7:0] PW = 8'h08, BC = 8'h04, OW = 8'h02, HL = 8'h01, NO = 8'h00;

  multicycle_ctrl #(.OP_W(4), .FN_W(3)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct),
    .MemReady(MemReady), .InValid(InValid), .OutReady(OutReady),
    .ALUOp(ALUOp), .SrcA(SrcA), .SrcB(SrcB), .MemtoReg(MemtoReg), .RegDest(RegDest),
    .PCSrc(PCSrc), .MemSrc(MemSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .BranchCond(BranchCond),
    .OutputWrite(OutputWrite), .Halted(Halted), .State(State)
  );

  always #5 CLK = ~CLK;

  logic [25:0] obs;
  assign obs = {State, ALUOp, SrcA, SrcB, MemtoReg, RegDest, PCSrc, MemSrc,
                RegWrite, MemRead, MemWrite, IRWrite, PCWrite, BranchCond, OutputWrite, Halted};

  function automatic logic [25:0] mk(input state_t s, input logic [2:0] alu, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] m2r,
                                     input logic [1:0] rd, input logic [1:0] pcs,
                                     input logic ms, input logic [7:0] st);
    return {s, alu, sa, sb, m2r, rd, pcs, ms, st};
  endfunction

  task automatic chk(input string tag, input logic [25:0] e);
    logic [25:0] want, got;
    sb_q.push_back(e);
    #1;
    got  = obs;
    want = sb_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input string tag, input logic [25:0] e);
    chk(tag, e);
    @(negedge CLK);
  endtask

  logic [25:0] zero_w, fetch_go, fetch_wait, decode_w;

  initial begin
    zero_w     = mk(S_FETCH, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, NO);
    fetch_go   = mk(S_FETCH, ALU_ADD, 1'b0, SRCB_ONE, 2'd0, 2'd0, 2'd0, 1'b0, MR | IR | PW);
    fetch_wait = mk(S_FETCH, ALU_ADD, 1'b0, SRCB_ONE, 2'd0, 2'd0, 2'd0, 1'b0, MR);
    decode_w   = mk(S_DECODE, ALU_ADD, 1'b1, SRCB_B, 2'd0, 2'd0, 2'd0, 1'b0, NO);

    Reset_n = 1'b0; Opcode = 4'd0; Funct = 3'd0;
    MemReady = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    #2 chk("reset", zero_w);
    @(negedge CLK); Reset_n = 1'b1;
    chk("release_idle", zero_w);
    @(negedge CLK);
    step("fetch_wait", fetch_wait);

    // addi
    Opcode = 4'd1; MemReady = 1'b1;
    step("addi_fetch", fetch_go);
    step("addi_decode", decode_w);
    step("addi_imm", mk(S_IMM, ALU_ADD, 1'b1, SRCB_IMM, 2'd0, 2'd0, 2'd0, 1'b0, NO));
    step("addi_imm2", mk(S_IMM2, 3'b000, 1'b0, 2'd0, WB_ALU, DST_RT, 2'd0, 1'b0, RW));

    // ori: opcode 0100 uses ALUOp 001
    Opcode = 4'd4;
    step("ori_fetch", fetch_go);
    step("ori_decode", decode_w);
    step("ori_imm", mk(S_IMM, ALU_OR, 1'b1, SRCB_IMM, 2'd0, 2'd0, 2'd0, 1'b0, NO));
    step("ori_imm2", mk(S_IMM2, 3'b000, 1'b0, 2'd0, WB_ALU, DST_RT, 2'd0, 1'b0, RW));

    // R-type, funct 110
    Opcode = 4'd0; Funct = 3'b110;
    step("rt_fetch", fetch_go);
    step("rt_decode", decode_w);
    step("rt_alu", mk(S_RTYPE, 3'b110, 1'b1, SRCB_B, 2'd0, 2'd0, 2'd0, 1'b0, NO));
    step("rt_wb", mk(S_RWRITE, 3'b000, 1'b0, 2'd0, WB_ALU, DST_RD, 2'd0, 1'b0, RW));

    // lw with two wait cycles
    Opcode = 4'd2; Funct = 3'd0;
    step("lw_fetch", fetch_go);
    step("lw_decode", decode_w);
    step("lw_addr", mk(S_ADDR, ALU_ADD, 1'b1, SRCB_IMM, 2'd0, 2'd0, 2'd0, 1'b0, NO));
    MemReady = 1'b0;
    step("lw1_wait0", mk(S_LW1, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, MR));
    step("lw1_wait1", mk(S_LW1, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, MR));
    MemReady = 1'b1;
    step("lw1_ready", mk(S_LW1, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, MR));
    step("lw2", mk(S_LW2, 3'b000, 1'b0, 2'd0, WB_MDR, DST_RT, 2'd0, 1'b0, RW));

    // in: InValid arrives on the fourth IN cycle
    Opcode = 4'd12; Funct = 3'b001;
    step("in_fetch", fetch_go);
    step("in_decode", decode_w);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++)
      step("in_wait", mk(S_IN, 3'b000, 1'b0, 2'd0, WB_IN, DST_RD, 2'd0, 1'b0, NO));
    InValid = 1'b1;
    step("in_valid", mk(S_IN, 3'b000, 1'b0, 2'd0, WB_IN, DST_RD, 2'd0, 1'b0, RW));
    InValid = 1'b0;

    // out
    Funct = 3'b000; MemReady = 1'b1;
    step("out_fetch", fetch_go);
    step("out_decode", decode_w);
    step("out_wait", mk(S_OUT, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, OW));
    OutReady = 1'b1;
    step("out_ready", mk(S_OUT, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, OW));
    OutReady = 1'b0;

    // bne, beq
    Opcode = 4'd8;
    step("bne_fetch", fetch_go);
    step("bne_decode", decode_w);
    step("bne", mk(S_BNE, ALU_SUB, 1'b1, SRCB_B, 2'd0, 2'd0, PC_ALU, 1'b0, PW));
    Opcode = 4'd7;
    step("beq_fetch", fetch_go);
    step("beq_decode", decode_w);
    step("beq", mk(S_BEQ, ALU_SUB, 1'b1, SRCB_B, 2'd0, 2'd0, PC_ALU, 1'b0, PW | BC));

    // jal, jr, jmp
    Opcode = 4'd10;
    step("jal_fetch", fetch_go);
    step("jal_decode", decode_w);
    step("jal1", mk(S_JAL1, ALU_ADD, 1'b0, SRCB_ONE, 2'd0, 2'd0, 2'd0, 1'b0, NO));
    step("jal2", mk(S_JAL2, 3'b000, 1'b0, 2'd0, WB_ALU, DST_RA, PC_JUMP, 1'b0, RW | PW));
    Opcode = 4'd11;
    step("jr_fetch", fetch_go);
    step("jr_decode", decode_w);
    step("jr", mk(S_JR, ALU_ADD, 1'b1, SRCB_B, 2'd0, 2'd0, PC_ALU, 1'b0, PW));
    Opcode = 4'd9;
    step("jmp_fetch", fetch_go);
    step("jmp_decode", decode_w);
    step("jmp", mk(S_JMP, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, PC_JUMP, 1'b0, PW));

    // sw interrupted by an asynchronous reset
    Opcode = 4'd3;
    step("sw_fetch", fetch_go);
    step("sw_decode", decode_w);
    step("sw_addr", mk(S_ADDR, ALU_ADD, 1'b1, SRCB_IMM, 2'd0, 2'd0, 2'd0, 1'b0, NO));
    MemReady = 1'b0;
    step("sw_wait0", mk(S_SW, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, MW));
    chk("sw_wait1", mk(S_SW, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, MW));
    #2 Reset_n = 1'b0;
    chk("sw_async_reset", zero_w);
    @(negedge CLK); Reset_n = 1'b1;
    chk("sw_release_idle", zero_w);
    @(negedge CLK);

    // illegal opcode 1110 halts until reset
    Opcode = 4'd14; MemReady = 1'b1;
    step("resume_fetch", fetch_go);
    step("ill_decode", decode_w);
    for (int i = 0; i < 20; i++)
      step("halt", mk(S_HALT, 3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, HL));
    Reset_n = 1'b0;
    chk("halt_async_reset", zero_w);
    @(negedge CLK); Reset_n = 1'b1;
    @(negedge CLK);
    MemReady = 1'b0;
    step("post_halt_fetch", fetch_wait);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width (4..6); unlisted opcodes are illegal.
REQ-002 SHALL have parameter FN_W, default 3, funct width (>=3); low 3 bits drive ALUOp.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: CLK in 1 rising-edge clock; Reset_n in 1 asynchronous active-low reset.
REQ-004 Opcode in OP_W instruction opcode field (IR), stable from DECODE to FETCH.
REQ-005 Funct in FN_W funct field.
REQ-006 MemReady in 1 memory access complete this cycle.
REQ-007 InValid in 1 input port holds data.
REQ-008 OutReady in 1 output port accepts data.
REQ-009 ALUOp out 3 ALU operation.
REQ-010 SrcA out 1 ALU A select: 0=PC, 1=A.
REQ-011 SrcB out 2 ALU B select: 0=B, 1=const 1, 2=SE imm.
REQ-012 MemtoReg out 2 write-back source: 0=MDR, 1=ALUOut, 2=input port.
REQ-013 RegDest out 2 destination: 0=rt, 1=rd, 2=$ra.
REQ-014 PCSrc out 2 PC source: 0=ALU, 1=jump target.
REQ-015 MemSrc out 1 memory address: 0=PC, 1=ALUOut.
REQ-016 RegWrite, MemRead, MemWrite, IRWrite, PCWrite out 1 each: datapath strobes.
REQ-017 BranchCond out 1 PCWrite qualifier: 1=on zero (beq), 0=on nonzero (bne).
REQ-018 OutputWrite out 1 output-port valid.
REQ-019 Halted out 1 high in HALT.
REQ-020 State out 5 current state code, debug.

Function
REQ-021 Moore outputs from state only; outside the active states below, all strobes 0 and all selects/ALUOp 0, no latches.
REQ-022 FETCH: MemRead=1, MemSrc=0, SrcA=0, SrcB=1, ALUOp=010; IRWrite=PCWrite=MemReady; to DECODE only when MemReady=1, else stay.
REQ-023 DECODE: SrcA=1, SrcB=0, ALUOp=010; 0000->RTYPE, 0001/0100/0101->IMM, 0010/0011->ADDR, 0111->BEQ, 1000->BNE, 1001->JMP, 1010->JAL1, 1011->JR, 1100->(Funct[0]?IN:OUT), 1111->HALT, illegal->HALT.
REQ-024 RTYPE: SrcA=1, SrcB=0, ALUOp=Funct[2:0]; ->RWRITE (RegWrite, MemtoReg=1, RegDest=1) ->FETCH.
REQ-025 IMM: SrcA=1, SrcB=2, ALUOp=010 for 0001, 001 for 0100, 000 for 0101; ->IMM2 (RegWrite, MemtoReg=1, RegDest=0) ->FETCH.
REQ-026 ADDR: SrcA=1, SrcB=2, ALUOp=010; ->LW1 if 0010, else SW.
REQ-027 SW: MemWrite=1, MemSrc=1; hold until MemReady, then FETCH.
REQ-028 LW1: MemRead=1, MemSrc=1; hold until MemReady, then LW2 (RegWrite, MemtoReg=0, RegDest=0) ->FETCH.
REQ-029 JAL1: SrcA=0, SrcB=1, ALUOp=010 ->JAL2 (RegWrite, MemtoReg=1, RegDest=2, PCWrite, PCSrc=1) ->FETCH.
REQ-030 JR: SrcA=1, SrcB=0, ALUOp=010, PCWrite, PCSrc=0; JMP: PCWrite, PCSrc=1; both ->FETCH.
REQ-031 BEQ/BNE: SrcA=1, SrcB=0, ALUOp=011, PCWrite, PCSrc=0, BranchCond=1/0; ->FETCH.
REQ-032 IN: MemtoReg=2, RegDest=1, RegWrite=InValid; ->FETCH on InValid, else stay. OUT: OutputWrite=1 until OutReady; ->FETCH on OutReady.
REQ-033 HALT: absorbing, Halted=1, all strobes 0; exits only by reset.
REQ-034 Wait states unbounded; strobes on handshake cycles occur exactly once per instruction.

Reset
REQ-035 Reset_n=0 SHALL force FETCH asynchronously; all strobes, Halted and OutputWrite 0; selects 0; State=0.
REQ-036 Reset mid-instruction SHALL abandon it with no further strobe; first FETCH begins on the first CLK edge after Reset_n rises.

Structure
REQ-037 State codes, opcode values and ALUOp codes SHALL live in a shared package (ctrl_pkg), used by datapath and bench.
REQ-038 Opcode decode SHALL be a combinational sub-module ctrl_decode (Opcode, Funct -> next-state class); the FSM stays in multicycle_ctrl.

Verification
REQ-039 addi (0001), MemReady=1 -> FETCH,DECODE,IMM,IMM2,FETCH; one RegWrite pulse, MemtoReg=1, RegDest=0.
REQ-040 lw (0010), MemReady low 2 cycles in LW1 -> LW1 held 3 cycles, MemRead=1 throughout, single RegWrite in LW2.
REQ-041 in (1100, Funct=001), InValid after 4 cycles -> IN held 4 cycles, RegWrite=1 only in the InValid cycle, MemtoReg=2.
REQ-042 bne (1000) -> BNE: ALUOp=011, PCWrite=1, BranchCond=0 for one cycle, then FETCH.
REQ-043 illegal opcode 1110 -> HALT, Halted=1 for 20 cycles; Reset_n pulse -> State=0 immediately.
REQ-044 Reset_n asserted mid-SW (MemReady=0) -> MemWrite drops without a CLK edge; FETCH resumes after release.
